// File: rtl/switch_box_tracks.sv
// switch_box_tracks: per-track N/E/S/W directional switch box.
// Config is scan-loaded into a shadow register and committed atomically to the active config.
module switch_box_tracks #(
    parameter int WIDTH   = 8,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_en,
    input  logic             cfg_in,
    input  logic             cfg_commit,
    output logic             cfg_out,
    output logic             cfg_full,
    input  logic [WIDTH-1:0] n_in,
    input  logic [WIDTH-1:0] e_in,
    input  logic [WIDTH-1:0] s_in,
    input  logic [WIDTH-1:0] w_in,
    output logic [WIDTH-1:0] n_out,
    output logic [WIDTH-1:0] e_out,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] w_out,
    output logic [WIDTH-1:0] n_oe,
    output logic [WIDTH-1:0] e_oe,
    output logic [WIDTH-1:0] s_oe,
    output logic [WIDTH-1:0] w_oe
);
    localparam int CFG_BITS = 12 * WIDTH;
    localparam int CW = $clog2(CFG_BITS + 1);
    localparam logic [CW-1:0] FULL = CW'(CFG_BITS);

    logic [CFG_BITS-1:0] shadow_q, shadow_d, active_q, active_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    side_in [4];
    logic [WIDTH-1:0]    out_d [4];
    logic [WIDTH-1:0]    oe_d [4];
    logic [WIDTH-1:0]    out_v [4];
    logic [WIDTH-1:0]    oe_v [4];

    assign side_in[0] = n_in;
    assign side_in[1] = e_in;
    assign side_in[2] = s_in;
    assign side_in[3] = w_in;

    // A simultaneous commit captures the pre-shift shadow; that shift counts as the first of the next load.
    always_comb begin
        shadow_d = cfg_en ? {shadow_q[CFG_BITS-2:0], cfg_in} : shadow_q;
        active_d = cfg_commit ? shadow_q : active_q;
        cnt_d    = cfg_commit ? CW'(cfg_en) : (cfg_en && cnt_q != FULL) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    // Field {en, sel} per track/side; self-select is treated as disabled.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            out_d[k] = '0;
            oe_d[k]  = '0;
            for (int t = 0; t < WIDTH; t++) begin
                oe_d[k][t]  = active_q[t*12 + k*3 + 2] && (active_q[t*12 + k*3 +: 2] != 2'(k));
                out_d[k][t] = oe_d[k][t] && side_in[active_q[t*12 + k*3 +: 2]][t];
            end
        end
    end

    generate
        if (REG_OUT) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_v <= '{default: '0};
                    oe_v  <= '{default: '0};
                end else begin
                    out_v <= out_d;
                    oe_v  <= oe_d;
                end
            end
        end else begin : g_comb
            assign out_v = out_d;
            assign oe_v  = oe_d;
        end
    endgenerate

    assign n_out    = out_v[0];
    assign e_out    = out_v[1];
    assign s_out    = out_v[2];
    assign w_out    = out_v[3];
    assign n_oe     = oe_v[0];
    assign e_oe     = oe_v[1];
    assign s_oe     = oe_v[2];
    assign w_oe     = oe_v[3];
    assign cfg_out  = shadow_q[CFG_BITS-1];
    assign cfg_full = (cnt_q == FULL);
endmodule
